// File: rtl/btc_dec_comp_code_lrb_search.sv
// Component-code decoder front stage.
// Consumes one saturated a-priori metric (Lapri) per beat. For each codeword it
// accumulates the hard decisions, the extended Hamming syndrome, the overall
// parity and the pLRB_NUM least reliable positions. One result vector is issued
// per codeword, one enabled cycle after its eop beat.
//
// Ports
//   iclk, ireset (sync, active high), iclkena (global hold when low)
//   ival/isop/ieop/iLapri : serial metric stream, one bit position per beat
//   oval       : one-cycle result strobe
//   olen       : codeword length in beats (saturates at 2^pIDX_W)
//   osyndrome  : XOR of (i+1) over hd=1 positions, eop position excluded
//   oparity    : XOR of all hard decisions
//   olrb_idx   : LRB positions, entry k at [k*pIDX_W +: pIDX_W], ascending magnitude
//   olrb_mag   : LRB magnitudes, entry k at [k*(pEXTR_W-1) +: pEXTR_W-1]
//   ohd_word   : hard-decision word, bit i = position i
//   oerr       : codeword exceeded 2^pIDX_W beats
module btc_dec_comp_code_lrb_search #(
  parameter int pEXTR_W  = 5,
  parameter int pIDX_W   = 6,
  parameter int pLRB_NUM = 2
) (
  input  logic                              iclk,
  input  logic                              ireset,
  input  logic                              iclkena,
  input  logic                              ival,
  input  logic                              isop,
  input  logic                              ieop,
  input  logic [pEXTR_W-1:0]                iLapri,
  output logic                              oval,
  output logic [pIDX_W:0]                   olen,
  output logic [pIDX_W-1:0]                 osyndrome,
  output logic                              oparity,
  output logic [pLRB_NUM*pIDX_W-1:0]        olrb_idx,
  output logic [pLRB_NUM*(pEXTR_W-1)-1:0]   olrb_mag,
  output logic [2**pIDX_W-1:0]              ohd_word,
  output logic                              oerr
);

  localparam int MW   = pEXTR_W - 1;
  localparam int NBIT = 2 ** pIDX_W;
  localparam logic [pIDX_W:0] FULL = {1'b1, {pIDX_W{1'b0}}};

  typedef enum logic {IDLE, ACC} state_t;

  state_t                             state;
  logic [pIDX_W:0]                    cnt;
  logic [NBIT-1:0]                    hd_acc;
  logic [pIDX_W-1:0]                  syn;
  logic                               par;
  logic                               ovf;
  logic [pLRB_NUM-1:0][pIDX_W-1:0]    lidx;
  logic [pLRB_NUM-1:0][MW-1:0]        lmag;

  // per-beat metric decode
  logic              hd;
  logic [pEXTR_W-1:0] neg;
  logic [MW-1:0]     mag;

  assign hd  = ~iLapri[pEXTR_W-1];
  assign neg = ~iLapri + 1'b1;
  // only the most negative code still has its sign set after negation
  assign mag = hd ? iLapri[MW-1:0] : (neg[pEXTR_W-1] ? '1 : neg[MW-1:0]);

  logic take;
  assign take = ival & (isop | (state == ACC));

  // Starting point for this beat. A sop clears everything (LRB list to
  // {0, all ones}); inserting the sop beat into that cleared list yields the
  // required seed {0, mag}, {0, all ones}, ... so sop needs no special path.
  logic [pIDX_W:0]                    base_cnt;
  logic [NBIT-1:0]                    base_hd;
  logic [pIDX_W-1:0]                  base_syn;
  logic                               base_par;
  logic                               base_ovf;
  logic [pLRB_NUM-1:0][pIDX_W-1:0]    base_lidx;
  logic [pLRB_NUM-1:0][MW-1:0]        base_lmag;

  always_comb begin
    base_cnt  = cnt;
    base_hd   = hd_acc;
    base_syn  = syn;
    base_par  = par;
    base_ovf  = ovf;
    base_lidx = lidx;
    base_lmag = lmag;
    if (isop) begin
      base_cnt  = '0;
      base_hd   = '0;
      base_syn  = '0;
      base_par  = 1'b0;
      base_ovf  = 1'b0;
      base_lidx = '0;
      base_lmag = '1;
    end
  end

  logic [pIDX_W-1:0] pos;
  logic              in_rng;
  assign pos    = base_cnt[pIDX_W-1:0];
  assign in_rng = (base_cnt != FULL);

  // Sorted insertion. lt[] is monotonic over a sorted list, so the insertion
  // point is the first k with lt[k]; a tie never inserts ahead of an equal entry.
  logic [pLRB_NUM-1:0]                lt;
  logic [pLRB_NUM-1:0][pIDX_W-1:0]    ins_lidx;
  logic [pLRB_NUM-1:0][MW-1:0]        ins_lmag;

  for (genvar k = 0; k < pLRB_NUM; k++) begin : g_ins
    assign lt[k] = (mag < base_lmag[k]);
    if (k == 0) begin : g_head
      assign ins_lidx[k] = lt[k] ? pos : base_lidx[k];
      assign ins_lmag[k] = lt[k] ? mag : base_lmag[k];
    end else begin : g_tail
      assign ins_lidx[k] = !lt[k] ? base_lidx[k] : (lt[k-1] ? base_lidx[k-1] : pos);
      assign ins_lmag[k] = !lt[k] ? base_lmag[k] : (lt[k-1] ? base_lmag[k-1] : mag);
    end
  end

  logic [pIDX_W:0]                    nxt_cnt;
  logic [NBIT-1:0]                    nxt_hd;
  logic [pIDX_W-1:0]                  nxt_syn;
  logic                               nxt_par;
  logic                               nxt_ovf;
  logic [pLRB_NUM-1:0][pIDX_W-1:0]    nxt_lidx;
  logic [pLRB_NUM-1:0][MW-1:0]        nxt_lmag;

  always_comb begin
    nxt_cnt  = base_cnt;
    nxt_hd   = base_hd;
    nxt_syn  = base_syn;
    nxt_par  = base_par ^ hd;
    nxt_ovf  = base_ovf;
    nxt_lidx = base_lidx;
    nxt_lmag = base_lmag;
    if (in_rng) begin
      nxt_cnt     = base_cnt + 1'b1;
      nxt_hd[pos] = hd;
      // eop is the extension bit; pos+1 wraps to 0 on the last slot by design
      if (hd && !ieop) nxt_syn = base_syn ^ (pos + 1'b1);
      nxt_lidx = ins_lidx;
      nxt_lmag = ins_lmag;
    end else begin
      // saturated: only parity keeps moving
      nxt_ovf = 1'b1;
    end
  end

  always_ff @(posedge iclk) begin
    if (ireset) begin
      state     <= IDLE;
      cnt       <= '0;
      hd_acc    <= '0;
      syn       <= '0;
      par       <= 1'b0;
      ovf       <= 1'b0;
      lidx      <= '0;
      lmag      <= '1;
      oval      <= 1'b0;
      oerr      <= 1'b0;
      oparity   <= 1'b0;
      olen      <= '0;
      osyndrome <= '0;
      olrb_idx  <= '0;
      olrb_mag  <= '1;
      ohd_word  <= '0;
    end else if (iclkena) begin
      oval <= take & ieop;
      if (take) begin
        cnt    <= nxt_cnt;
        hd_acc <= nxt_hd;
        syn    <= nxt_syn;
        par    <= nxt_par;
        ovf    <= nxt_ovf;
        lidx   <= nxt_lidx;
        lmag   <= nxt_lmag;
        state  <= ieop ? IDLE : ACC;
        if (ieop) begin
          olen      <= nxt_cnt;
          osyndrome <= nxt_syn;
          oparity   <= nxt_par;
          oerr      <= nxt_ovf;
          ohd_word  <= nxt_hd;
          for (int k = 0; k < pLRB_NUM; k++) begin
            olrb_idx[k*pIDX_W +: pIDX_W] <= nxt_lidx[k];
            olrb_mag[k*MW +: MW]         <= nxt_lmag[k];
          end
        end
      end
    end
  end

endmodule
